// File: rtl/pipe_pkg.sv
// Shared MEM/WB pipeline types: payload and control field layouts, plus the
// occupancy states of the skid stage between MEM and WB.
package pipe_pkg;

  // Three spare bits keep the payload byte-aligned at 136 bits.
  typedef struct packed {
    logic [2:0]  spare;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] dmem;
  } memwb_data_t;

  typedef struct packed {
    logic [1:0] wb_sel;
    logic       reg_write_en;
  } memwb_ctrl_t;

  localparam int MEMWB_DATA_W = $bits(memwb_data_t);
  localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);

  // Encoding equals the number of words held, so it doubles as OCCUPANCY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between MEM and WB: full throughput with a registered
// IN_READY, flush support and a saturating downstream bubble counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  input  logic              FLUSH,
  output logic [1:0]        OCCUPANCY,
  output logic [CNT_W-1:0]  BUBBLE_CNT
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              out_valid, accept, pop;

  // Ready depends only on the state register, never on OUT_READY.
  assign IN_READY  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = IN_VALID & IN_READY;
  assign pop       = out_valid & OUT_READY;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a combinational output unassigned and no latch is inferred.
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    bubble_d    = bubble_q;

    if (OUT_READY && !out_valid && (bubble_q != '1)) begin
      bubble_d = bubble_q + 1'b1;
    end

    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
          end
        end
        ST_ONE: begin
          case ({accept, pop})
            2'b11: begin
              main_data_d = IN_DATA;
              main_ctrl_d = IN_CTRL;
            end
            2'b10: begin
              state_d     = ST_FULL;
              skid_data_d = IN_DATA;
              skid_ctrl_d = IN_CTRL;
            end
            2'b01:   state_d = ST_EMPTY;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      bubble_q    <= bubble_d;
    end
  end

  // NOTE: the skid payload is never read before it is written, so it carries
  // no reset and stays a plain data register.
  always_ff @(posedge CLK) begin
    skid_data_q <= skid_data_d;
  end

  assign OUT_VALID  = out_valid;
  assign OUT_DATA   = main_data_q;
  assign OUT_CTRL   = out_valid ? main_ctrl_q : '0;
  assign OCCUPANCY  = state_q;
  assign BUBBLE_CNT = bubble_q;

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 136, width of the unreset payload (rd[4:0], PC+4, ALU result, immediate, DMEM out).
REQ-002 SHALL have parameter CTRL_W, default 3, width of the control field (WB_SEL[1:0], REG_WRITE_EN); control bits are zeroed in bubbles.
REQ-003 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port IN_VALID  input  1  upstream word valid.
REQ-007 SHALL have port IN_READY  output  1  stage can accept; registered, no combinational path from OUT_READY.
REQ-008 SHALL have port IN_DATA  input  DATA_W  upstream payload.
REQ-009 SHALL have port IN_CTRL  input  CTRL_W  upstream control.
REQ-010 SHALL have port OUT_VALID  output  1  downstream word valid.
REQ-011 SHALL have port OUT_READY  input  1  downstream accepts.
REQ-012 SHALL have port OUT_DATA  output  DATA_W  head payload.
REQ-013 SHALL have port OUT_CTRL  output  CTRL_W  head control; all-zero whenever OUT_VALID=0.
REQ-014 SHALL have port FLUSH  input  1  discard all held words (branch/trap kill).
REQ-015 SHALL have port OCCUPANCY  output  2  words held (0..2).
REQ-016 SHALL have port BUBBLE_CNT  output  CNT_W  saturating count of cycles with OUT_READY=1 and OUT_VALID=0.

Function
REQ-017 SHALL hold two entries, MAIN (drives outputs) and SKID; states EMPTY (0 held), ONE (MAIN only), FULL (MAIN+SKID).
REQ-018 SHALL accept a word on IN_VALID & IN_READY and present it on OUT_* exactly 1 cycle later when the stage was EMPTY or ONE-draining.
REQ-019 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on pop without accept; ONE->ONE on accept+pop (MAIN replaced); ONE->FULL on accept without pop (word to SKID); FULL->ONE on pop (SKID moves to MAIN).
REQ-020 SHALL drive IN_READY = 1 in EMPTY and ONE, 0 in FULL, from registered state only.
REQ-021 SHALL sustain one word per cycle when OUT_READY is held 1.
REQ-022 SHALL keep OUT_DATA/OUT_CTRL stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 SHALL preserve word order through SKID; no word lost or duplicated.
REQ-024 SHALL, on FLUSH=1, go to EMPTY next cycle, discarding MAIN, SKID and any word accepted in the same cycle; FLUSH overrides all handshakes.
REQ-025 SHALL leave OUT_DATA at its last value when OUT_VALID=0 (no clearing of payload).
REQ-026 SHALL increment BUBBLE_CNT in cycles with OUT_READY=1 and OUT_VALID=0, saturating at all-ones; FLUSH does not clear it.
REQ-027 SHALL have OCCUPANCY = 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-028 SHALL, when RST=1 at a rising CLK, force state EMPTY, OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0, BUBBLE_CNT=0, IN_READY=1 from the next cycle; RST overrides FLUSH and handshakes.
REQ-029 SHALL reset OUT_DATA to 0; SKID payload is not reset.
REQ-030 SHALL drive no X on any control output after reset (control fields reset to 0, never X).

Structure
REQ-031 SHALL take DATA_W/CTRL_W defaults and the packed MEM/WB payload and control typedefs (field order rd, pc4, alu, imm, dmem; wb_sel, reg_write_en) from shared package pipe_pkg.
REQ-032 SHALL be a single module with no sub-modules; the bubble counter is inline.

Verification
REQ-033 SHALL cover: reset, then IN_VALID=1 IN_DATA=0x...A5 IN_CTRL=3'b011 OUT_READY=1 -> OUT_VALID=1 with same data/ctrl next cycle, OCCUPANCY=1.
REQ-034 SHALL cover: streaming words 1..8 with OUT_READY=1 -> 8 outputs in order on 8 consecutive cycles, IN_READY never 0.
REQ-035 SHALL cover: OUT_READY=0, push words 1,2 -> OCCUPANCY=2, IN_READY=0, OUT_DATA=1 stable; OUT_READY=1 -> outputs 1 then 2, IN_READY=1 after first pop.
REQ-036 SHALL cover: FULL with words 1,2 plus FLUSH=1 -> next cycle OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0; no word 1/2 ever popped.
REQ-037 SHALL cover: OUT_READY=1, IN_VALID=0 for 5 cycles -> BUBBLE_CNT=5; with CNT_W=2 -> saturates at 3.
REQ-038 SHALL cover: RST=1 asserted while FULL -> next cycle all outputs at reset values, BUBBLE_CNT=0, no X on OUT_CTRL.
